// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong match sequencer.
//   state_e        match FSM states
//   DIR_LEFT/RIGHT serve direction encoding
//   ENT_*          entropy[4:3] codes per serve direction
//   LFSR_SEED      reset value of the serve-randomising LFSR
//   make_entropy   builds the 5-bit serve code from direction and LFSR bits
//   sat_inc4       4-bit saturating increment used by the score counters
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_RALLY,
    ST_POINT,
    ST_GAMEOVER
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Serving left uses codes {00,11}; serving right uses {01,10}.
  // lfsr[3] chooses between the two codes of a side.
  localparam logic [1:0] ENT_LEFT_A  = 2'b00;
  localparam logic [1:0] ENT_LEFT_B  = 2'b11;
  localparam logic [1:0] ENT_RIGHT_A = 2'b01;
  localparam logic [1:0] ENT_RIGHT_B = 2'b10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [4:0] make_entropy(input logic dir, input logic [3:0] rnd);
    logic [1:0] code;
    if (dir == DIR_LEFT) code = rnd[3] ? ENT_LEFT_B  : ENT_LEFT_A;
    else                 code = rnd[3] ? ENT_RIGHT_B : ENT_RIGHT_A;
    return {code, rnd[2:0]};
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
//   clk      system clock
//   reset_n  synchronous active-low reset, loads LFSR_SEED
//   state    current LFSR contents (never all-zero)
module lfsr16
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;
  logic        fb;

  always_comb begin
    fb      = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
    state_d = {state_q[14:0], fb};
    // A maximal-length sequence never reaches zero from a non-zero seed;
    // this only recovers from a corrupted (e.g. upset) register.
    if (state_d == '0) state_d = LFSR_SEED;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= LFSR_SEED;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencer for the pong ball datapath.
//   Runs IDLE -> SERVE (ball held centred) -> RALLY (speed ramp) ->
//   POINT (score) -> SERVE ... -> GAMEOVER. All outputs are registered.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start                 synchronised start button (rising edge used)
//   out_left, out_right   ball exited left / right edge (RALLY only)
//   ball_reset            holds ball centred; low only in RALLY
//   speed                 ball speed, START_SPEED..MAX_SPEED
//   entropy               serve direction/angle code, loaded on SERVE entry
//   score_l, score_r      player scores (saturate at 15)
//   game_over, winner     end of match and winning side (0 left, 1 right)
module match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_TICKS = 2000,
  parameter int RAMP_TICKS  = 4000,
  parameter int START_SPEED = 4,
  parameter int MAX_SPEED   = 15,
  parameter int WIN_SCORE   = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              out_left,
  input  logic              out_right,
  output logic              ball_reset,
  output logic signed [4:0] speed,
  output logic [4:0]        entropy,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic              game_over,
  output logic              winner
);

  localparam int CNT_W  = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int RAMP_W = (RAMP_TICKS  > 1) ? $clog2(RAMP_TICKS)  : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SERVE_TICKS - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
  localparam logic signed [4:0] SPD_START = 5'(START_SPEED);
  localparam logic signed [4:0] SPD_MAX   = 5'(MAX_SPEED);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

  state_e              state_q, state_d;
  logic                start_q, start_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic signed [4:0]   speed_q, speed_d;
  logic                dir_q, dir_d;
  logic [4:0]          entropy_q, entropy_d;
  logic [3:0]          score_l_q, score_l_d;
  logic [3:0]          score_r_q, score_r_d;
  logic                winner_q, winner_d;
  logic                game_over_q, game_over_d;
  logic                ball_reset_q, ball_reset_d;

  logic                start_rise;
  logic                load_ent;
  logic [15:0]         lfsr;
  logic                unused_lfsr;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  // Only the low nibble feeds the serve code.
  assign unused_lfsr = ^lfsr[15:4];

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d    = state_q;
    start_d    = start;
    cnt_d      = cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    speed_d    = speed_q;
    dir_d      = dir_q;
    entropy_d  = entropy_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    load_ent   = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_rise) begin
          state_d   = ST_SERVE;
          score_l_d = '0;
          score_r_d = '0;
          dir_d     = DIR_RIGHT;
          cnt_d     = '0;
          load_ent  = 1'b1;
        end
      end

      ST_SERVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_RALLY;
          speed_d    = SPD_START;
          ramp_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RALLY: begin
        // Ball events take priority over the speed ramp.
        if (out_left && out_right) begin
          // Let: re-serve in the same direction, no score.
          state_d  = ST_SERVE;
          cnt_d    = '0;
          load_ent = 1'b1;
        end else if (out_left) begin
          state_d   = ST_POINT;
          score_r_d = sat_inc4(score_r_q);
          dir_d     = DIR_LEFT;
        end else if (out_right) begin
          state_d   = ST_POINT;
          score_l_d = sat_inc4(score_l_q);
          dir_d     = DIR_RIGHT;
        end else if (ramp_cnt_q == RAMP_LAST) begin
          ramp_cnt_d = '0;
          if (speed_q < SPD_MAX) speed_d = speed_q + 5'sd1;
        end else begin
          ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
      end

      ST_POINT: begin
        if (score_l_q == WIN) begin
          state_d  = ST_GAMEOVER;
          winner_d = 1'b0;
        end else if (score_r_q == WIN) begin
          state_d  = ST_GAMEOVER;
          winner_d = 1'b1;
        end else begin
          state_d  = ST_SERVE;
          cnt_d    = '0;
          load_ent = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Serve code uses the direction chosen on this same transition.
    if (load_ent) entropy_d = make_entropy(dir_d, lfsr[3:0]);

    // Decoded from the next state so these outputs stay registered and
    // aligned with state_q.
    ball_reset_d = (state_d != ST_RALLY);
    game_over_d  = (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      ramp_cnt_q   <= '0;
      speed_q      <= SPD_START;
      dir_q        <= DIR_RIGHT;
      entropy_q    <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= 1'b0;
      game_over_q  <= 1'b0;
      ball_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      ramp_cnt_q   <= ramp_cnt_d;
      speed_q      <= speed_d;
      dir_q        <= dir_d;
      entropy_q    <= entropy_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      game_over_q  <= game_over_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  assign ball_reset = ball_reset_q;
  assign speed      = speed_q;
  assign entropy    = entropy_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed self-checking bench for match_ctrl with short
// serve/ramp periods and WIN_SCORE = 3.
module tb_match_ctrl;

  localparam int ST = 8;   // SERVE_TICKS
  localparam int RT = 4;   // RAMP_TICKS
  localparam int SS = 4;   // START_SPEED
  localparam int MS = 15;  // MAX_SPEED
  localparam int WS = 3;   // WIN_SCORE

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              out_left = 1'b0;
  logic              out_right = 1'b0;
  logic              ball_reset;
  logic signed [4:0] speed;
  logic [4:0]        entropy;
  logic [3:0]        score_l, score_r;
  logic              game_over, winner;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] ent_hold;

  always #5 clk = ~clk;

  match_ctrl #(
    .SERVE_TICKS (ST),
    .RAMP_TICKS  (RT),
    .START_SPEED (SS),
    .MAX_SPEED   (MS),
    .WIN_SCORE   (WS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .out_left   (out_left),
    .out_right  (out_right),
    .ball_reset (ball_reset),
    .speed      (speed),
    .entropy    (entropy),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .winner     (winner)
  );

  // Advance one cycle; inputs and samples both sit 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ball_reset", ball_reset, 1);
    chk("rst_speed",      speed, SS);
    chk("rst_entropy",    entropy, 0);
    chk("rst_score_l",    score_l, 0);
    chk("rst_score_r",    score_r, 0);
    chk("rst_game_over",  game_over, 0);
    chk("rst_winner",     winner, 0);
  endtask

  // From the first SERVE cycle: ball held for exactly ST cycles, entropy
  // constant, then released into RALLY.
  task automatic serve_check(input string tag);
    ent_hold = entropy;
    for (int i = 0; i < ST; i++) begin
      chk({tag, "_hold"}, ball_reset, 1);
      chk({tag, "_ent_stable"}, entropy, ent_hold);
      tick();
    end
    chk({tag, "_release"}, ball_reset, 0);
    chk({tag, "_speed"}, speed, SS);
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    chk_reset();
    reset_n = 1'b1;
    tick();

    // Ball events in IDLE are ignored
    out_left = 1'b1; tick();
    out_left = 1'b0; out_right = 1'b1; tick();
    out_right = 1'b0; tick();
    chk("idle_evt_score_l", score_l, 0);
    chk("idle_evt_score_r", score_r, 0);
    chk("idle_evt_ball_reset", ball_reset, 1);

    // Start pulse -> SERVE toward the right
    start = 1'b1; tick(); start = 1'b0;
    chk("serve1_ent_right", (entropy[4:3] == 2'b01) || (entropy[4:3] == 2'b10), 1);
    serve_check("serve1");

    // Left-edge point
    out_left = 1'b1; tick(); out_left = 1'b0;
    chk("ptL_score_r", score_r, 1);
    chk("ptL_score_l", score_l, 0);
    chk("ptL_ball_reset", ball_reset, 1);
    tick();
    chk("ptL_serve_ent_left", (entropy[4:3] == 2'b00) || (entropy[4:3] == 2'b11), 1);
    serve_check("serve2");

    // Speed ramp 4 -> 15, then saturation
    for (int k = 1; k <= 13; k++) begin
      repeat (RT - 1) tick();
      chk("ramp_before", speed, (SS + k - 1 > MS) ? MS : SS + k - 1);
      tick();
      chk("ramp_step", speed, (SS + k > MS) ? MS : SS + k);
    end

    // Right-edge point, next serve restores start speed
    out_right = 1'b1; tick(); out_right = 1'b0;
    chk("ptR_score_l", score_l, 1);
    chk("ptR_score_r", score_r, 1);
    tick();
    chk("ptR_serve_ent_right", (entropy[4:3] == 2'b01) || (entropy[4:3] == 2'b10), 1);
    serve_check("serve3");

    // Let: both edges at once
    out_left = 1'b1; out_right = 1'b1; tick();
    out_left = 1'b0; out_right = 1'b0;
    chk("let_ball_reset", ball_reset, 1);
    chk("let_score_l", score_l, 1);
    chk("let_score_r", score_r, 1);
    chk("let_ent_right", (entropy[4:3] == 2'b01) || (entropy[4:3] == 2'b10), 1);
    // Event during SERVE is ignored and the serve keeps its length
    out_left = 1'b1; tick(); out_left = 1'b0;
    chk("serve_evt_score_r", score_r, 1);
    chk("serve_evt_ball_reset", ball_reset, 1);
    repeat (ST - 2) tick();
    chk("let_serve_still_held", ball_reset, 1);
    tick();
    chk("let_serve_release", ball_reset, 0);

    // Play out the game: two more right-edge points, left reaches 3
    out_right = 1'b1; tick(); out_right = 1'b0;
    chk("g2_score_l", score_l, 2);
    chk("g2_game_over", game_over, 0);
    tick();
    repeat (ST) tick();
    chk("g2_release", ball_reset, 0);
    start = 1'b1;  // held from before GAMEOVER: no edge afterwards
    out_right = 1'b1; tick(); out_right = 1'b0;
    chk("g3_score_l", score_l, 3);
    chk("g3_point_game_over", game_over, 0);
    tick();
    chk("go_game_over", game_over, 1);
    chk("go_winner", winner, 0);
    chk("go_ball_reset", ball_reset, 1);
    repeat (3) tick();
    out_left = 1'b1; tick(); out_left = 1'b0; tick();
    chk("go_held_game_over", game_over, 1);
    chk("go_held_score_l", score_l, 3);
    chk("go_held_score_r", score_r, 1);
    chk("go_held_winner", winner, 0);
    chk("go_held_ball_reset", ball_reset, 1);

    // New start edge restarts
    start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_game_over", game_over, 0);
    chk("restart_score_l", score_l, 0);
    chk("restart_score_r", score_r, 0);
    chk("restart_ent_right", (entropy[4:3] == 2'b01) || (entropy[4:3] == 2'b10), 1);
    serve_check("serve4");

    // Build a 2:1 score, then reset mid-rally
    out_right = 1'b1; tick(); out_right = 1'b0; tick(); repeat (ST) tick();
    out_right = 1'b1; tick(); out_right = 1'b0; tick(); repeat (ST) tick();
    out_left  = 1'b1; tick(); out_left  = 1'b0; tick(); repeat (ST) tick();
    chk("mid_score_l", score_l, 2);
    chk("mid_score_r", score_r, 1);
    chk("mid_in_rally", ball_reset, 0);
    repeat (RT) tick();
    chk("mid_speed", speed, SS + 1);
    tick();
    reset_n = 1'b0; tick();
    chk_reset();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", ball_reset, 1);
    chk("post_rst_score_l", score_l, 0);
    // From IDLE a start edge gives a full-length serve (cnt cleared)
    start = 1'b1; tick(); start = 1'b0;
    serve_check("serve5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the pong ball datapath. Owns the ball's reset, speed and serve-direction (entropy) inputs and consumes its out_left/out_right events. Runs the cycle start → serve pause → rally with speed ramp → point scoring → game over. Sits between the player start button, the ball block and the score display.

## Interface

**Parameters**
- SERVE_TICKS, 2000: cycles the ball is held centred before each rally (1 s at 2 kHz).
- RAMP_TICKS, 4000: rally cycles between speed increments.
- START_SPEED, 4: speed at each serve; must satisfy 1..MAX_SPEED.
- MAX_SPEED, 15: speed saturation value; must be ≤ 15.
- WIN_SCORE, 9: points needed to win; must be 1..15.

**Ports**
- clk, input, 1: system clock (ball tick clock).
- reset_n, input, 1: synchronous, active-low reset.
- start, input, 1: player start button, already synchronised. Acted on at its rising edge only.
- out_left, input, 1: ball exited the left edge; left player concedes.
- out_right, input, 1: ball exited the right edge; right player concedes.
- ball_reset, output, 1: active-high reset to the ball; holds it centred and makes it sample entropy.
- speed, output, signed 5: ball speed, always in START_SPEED..MAX_SPEED.
- entropy, output, 5: serve direction/angle code for the ball.
- score_l, output, 4: left player score.
- score_r, output, 4: right player score.
- game_over, output, 1: high in GAMEOVER.
- winner, output, 1: 0 = left, 1 = right; valid while game_over is high.

## Operation

- **States:** IDLE, SERVE, RALLY, POINT, GAMEOVER.
- **ball_reset:** low only in RALLY; high in every other state.
- **Start edge:** start_q is a registered copy of start; start_rise = start & ~start_q.
- **IDLE + start_rise → SERVE.** Clear scores; serve direction = right; cnt = 0.
- **SERVE:**
  - cnt increments each cycle.
  - At cnt == SERVE_TICKS-1, go to RALLY: speed = START_SPEED, ramp_cnt = 0.
- **RALLY, exactly one of out_left/out_right high → POINT.**
  - out_left: score_r += 1; next serve direction = left.
  - out_right: score_l += 1; next serve direction = right.
  - Scores saturate at 15.
- **RALLY, both events high in one cycle:** treated as a let. Go to SERVE with no score change, serve direction unchanged, cnt = 0.
- **RALLY speed ramp:**
  - ramp_cnt counts cycles.
  - At RAMP_TICKS-1: ramp_cnt = 0 and speed += 1, saturating at MAX_SPEED.
  - An out_* event in the same cycle takes priority; no speed change.
- **POINT (exactly 1 cycle):**
  - If score_l or score_r == WIN_SCORE: go to GAMEOVER; winner = side that reached it.
  - Otherwise go to SERVE with cnt = 0.
- **GAMEOVER:** scores and winner held. start_rise → SERVE with scores cleared and serve direction = right.
- **entropy:**
  - Loaded on every transition into SERVE and held constant until the next load.
  - entropy[2:0] = lfsr[2:0].
  - Direction left: entropy[4:3] = lfsr[3] ? 2'b11 : 2'b00.
  - Direction right: entropy[4:3] = lfsr[3] ? 2'b10 : 2'b01.
- **LFSR:**
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-running in every state; seed 16'hACE1 on reset.
  - Never all-zero.
- **out_left/out_right** are ignored outside RALLY.

## Timing

- **Reset values (reset_n low at a clk edge):** state IDLE, ball_reset 1, speed START_SPEED, entropy 0, score_l 0, score_r 0, game_over 0, winner 0, cnt 0, ramp_cnt 0, start_q 0.
- **Reset mid-operation:** reset wins over every other condition on that edge.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs.
- **out_* high in cycle N (RALLY):**
  - N+1: score updated and ball_reset = 1 (POINT).
  - N+2: SERVE or GAMEOVER.
- **Serve length:** ball_reset is high in SERVE for exactly SERVE_TICKS cycles, then low from the first RALLY cycle.
- **entropy stability:** valid from the first SERVE cycle and stable through the whole reset hold.
- **Speed changes:** only in RALLY; one step per RAMP_TICKS cycles.

## Structure

- **Shared package pong_pkg:**
  - state enum.
  - direction constants DIR_LEFT / DIR_RIGHT.
  - entropy direction codes (left {00,11}, right {01,10}).
  - LFSR seed.
- **Sub-module lfsr16:** clk, reset_n, 16-bit state output.
- **Counter widths:** sized by $clog2 of SERVE_TICKS and RAMP_TICKS.

## Test plan

- **Reset then start pulse:** after reset, pulse start.
  - Required: IDLE → SERVE.
  - Required: ball_reset high for exactly SERVE_TICKS cycles, then low.
  - Required: speed = 4.
  - Required: entropy[4:3] ∈ {01,10}.
- **Left-edge point:** out_left in RALLY for 1 cycle.
  - Required: next cycle score_r = 1 and ball_reset = 1.
  - Required: following SERVE has entropy[4:3] ∈ {00,11}.
  - Required: score_l unchanged.
- **Speed ramp:** hold RALLY for 13×RAMP_TICKS cycles.
  - Required: speed steps 4 → 15 at each RAMP_TICKS boundary, then stays 15.
  - Required: speed back to 4 after the next serve.
- **Game to completion:** WIN_SCORE = 3, three out_right events.
  - Required: score_l = 3, GAMEOVER, game_over = 1, winner = 0.
  - Required: held start (no new edge) causes no restart.
  - Required: a new edge clears scores and enters SERVE.
- **Let and idle-state events:**
  - Simultaneous out_left & out_right in RALLY → SERVE, scores unchanged.
  - out_* pulses in IDLE/SERVE/GAMEOVER → ignored.
- **Reset mid-rally:** reset_n low during RALLY with scores 2:1.
  - Required: next cycle all reset values, state IDLE.
